// File: rtl/mdarray_arbiter_if.sv
// mdarray_arbiter_if: requester A/B command channels plus the shared 3-D memory port
interface mdarray_arbiter_if #(
  parameter int IW = 2,
  parameter int DW = 8
);
  logic          a_req, a_wr, a_ack, a_rvalid;
  logic [IW-1:0] a_slc, a_row, a_col;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_wr, b_ack, b_rvalid;
  logic [IW-1:0] b_slc, b_row, b_col;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [IW-1:0] mem_slc, mem_row, mem_col;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport master (
    output a_req, a_wr, a_slc, a_row, a_col, a_wdata,
    input  a_ack, a_rvalid, a_rdata,
    output b_req, b_wr, b_slc, b_row, b_col, b_wdata,
    input  b_ack, b_rvalid, b_rdata,
    input  mem_slc, mem_row, mem_col, mem_wr, mem_wdata,
    output mem_rdata
  );
  modport slave (
    input  a_req, a_wr, a_slc, a_row, a_col, a_wdata,
    output a_ack, a_rvalid, a_rdata,
    input  b_req, b_wr, b_slc, b_row, b_col, b_wdata,
    output b_ack, b_rvalid, b_rdata,
    output mem_slc, mem_row, mem_col, mem_wr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mdarray_arbiter.sv
// mdarray_arbiter: round-robin A/B arbiter onto one 3-D memory port; MDARRAY_ARB_CLEAR_EN adds a sweep-clear sequencer
module mdarray_arbiter #(
  parameter int IW = 2,
  parameter int N = 4,
  parameter int DW = 8,
  parameter int RD_LAT = 2
) (
  input  logic clock,
  input  logic reset,
`ifdef MDARRAY_ARB_CLEAR_EN
  input  logic clr_start,
  output logic clr_busy,
  output logic clr_done,
`endif
  mdarray_arbiter_if.slave bus
);
  logic ptr_a, sweep, a_go, b_go;
  logic [RD_LAT:0] tag_v, tag_b;
  if (N > 2 ** IW) begin : g_bad_n
    $error("N does not fit in IW index bits");
  end
`ifdef MDARRAY_ARB_CLEAR_EN
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state;
  logic [IW-1:0] cs, cr, cc;
  assign sweep = clr_busy;
`else
  assign sweep = 1'b0;
`endif
  assign a_go = bus.a_req & ~sweep & (ptr_a | ~bus.b_req);
  assign b_go = bus.b_req & ~sweep & ~a_go;
  assign bus.a_ack = a_go;
  assign bus.b_ack = b_go;
  assign bus.a_rdata = bus.mem_rdata;
  assign bus.b_rdata = bus.mem_rdata;
  // Priority pointer, registered memory command and the optional sweep-clear FSM
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ptr_a <= 1'b1;
      bus.mem_wr <= 1'b0;
      bus.mem_slc <= '0;
      bus.mem_row <= '0;
      bus.mem_col <= '0;
      bus.mem_wdata <= '0;
`ifdef MDARRAY_ARB_CLEAR_EN
      state <= IDLE;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      cs <= '0;
      cr <= '0;
      cc <= '0;
`endif
    end else begin
      bus.mem_wr <= a_go | b_go;
      if (a_go | b_go) begin
        ptr_a <= b_go;
        bus.mem_slc <= a_go ? bus.a_slc : bus.b_slc;
        bus.mem_row <= a_go ? bus.a_row : bus.b_row;
        bus.mem_col <= a_go ? bus.a_col : bus.b_col;
        bus.mem_wr <= a_go ? bus.a_wr : bus.b_wr;
        bus.mem_wdata <= a_go ? bus.a_wdata : bus.b_wdata;
      end
`ifdef MDARRAY_ARB_CLEAR_EN
      clr_done <= 1'b0;
      if (state == IDLE && clr_start) begin
        state <= SWEEP;
        clr_busy <= 1'b1;
        cs <= '0;
        cr <= '0;
        cc <= '0;
      end else if (state == SWEEP) begin
        bus.mem_wr <= 1'b1;
        bus.mem_slc <= cs;
        bus.mem_row <= cr;
        bus.mem_col <= cc;
        bus.mem_wdata <= '0;
        cc <= cc == LAST ? '0 : cc + 1'b1;
        if (cc == LAST) cr <= cr == LAST ? '0 : cr + 1'b1;
        if (cc == LAST && cr == LAST) cs <= cs + 1'b1;
        if (cs == LAST && cr == LAST && cc == LAST) begin
          state <= DONE;
          clr_busy <= 1'b0;
          clr_done <= 1'b1;
        end
      end else if (state == DONE) state <= IDLE;
`endif
    end
  // Read-owner tags ride the pipeline; the owner's rvalid fires one edge after a tag reaches the end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tag_v <= '0;
      tag_b <= '0;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
    end else begin
      tag_v <= {tag_v[RD_LAT-1:0], (a_go & ~bus.a_wr) | (b_go & ~bus.b_wr)};
      tag_b <= {tag_b[RD_LAT-1:0], b_go};
      bus.a_rvalid <= tag_v[RD_LAT] & ~tag_b[RD_LAT];
      bus.b_rvalid <= tag_v[RD_LAT] & tag_b[RD_LAT];
    end
endmodule

// File: tb/tb_mdarray_arbiter.sv
// tb_mdarray_arbiter: randomized and directed checks of mdarray_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_mdarray_arbiter;
  localparam int IW = 2, N = 4, DW = 8, RD_LAT = 2;
  typedef struct packed {logic wr; logic [IW-1:0] s, r, c; logic [DW-1:0] d;} cmd_t;
  typedef struct {int due; bit b; logic [DW-1:0] d;} ret_t;
  logic clock = 0, reset = 1;
  int cyc = 0, n_tests = 0, n_fail = 0;
  mdarray_arbiter_if #(.IW(IW), .DW(DW)) bus();
`ifdef MDARRAY_ARB_CLEAR_EN
  logic clr_start = 0, clr_busy, clr_done;
`endif
  mdarray_arbiter #(.IW(IW), .N(N), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clock(clock),
    .reset(reset),
`ifdef MDARRAY_ARB_CLEAR_EN
    .clr_start(clr_start),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
`endif
    .bus(bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // memory: address captured one edge after the command register, data two edges later
  logic [DW-1:0] mem [N][N][N];
  logic [IW-1:0] ms, mr, mc;
  logic [DW-1:0] d1, rd;
  always @(posedge clock) begin
    if (bus.mem_wr) mem[bus.mem_slc][bus.mem_row][bus.mem_col] <= bus.mem_wdata;
    ms <= bus.mem_slc;
    mr <= bus.mem_row;
    mc <= bus.mem_col;
    d1 <= mem[ms][mr][mc];
    rd <= d1;
  end
  assign bus.mem_rdata = rd;
  // reference model state
  cmd_t qa[$], qb[$];
  ret_t rq[$];
  logic [DW-1:0] shadow [N][N][N];
  bit last_a = 0, exp_mwr = 0, exp_xfer = 0;
  cmd_t exp_cmd;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic cmd_t mk(bit wr, int s, int r, int c, int d);
    cmd_t x;
    x.wr = wr; x.s = IW'(s); x.r = IW'(r); x.c = IW'(c); x.d = DW'(d);
    return x;
  endfunction
  function automatic cmd_t rnd();
    return mk($urandom_range(1), $urandom_range(N - 1), $urandom_range(N - 1), $urandom_range(N - 1), $urandom);
  endfunction
  task automatic step();
    cmd_t ca, cb, x;
    bit ra, rb, ea, eb;
    ra = qa.size() > 0;
    rb = qb.size() > 0;
    ca = '0;
    cb = '0;
    if (ra) ca = qa[0];
    if (rb) cb = qb[0];
    bus.a_req = ra;
    {bus.a_wr, bus.a_slc, bus.a_row, bus.a_col, bus.a_wdata} = ca;
    bus.b_req = rb;
    {bus.b_wr, bus.b_slc, bus.b_row, bus.b_col, bus.b_wdata} = cb;
    @(negedge clock);
    ea = ra && (!rb || !last_a);
    eb = rb && !ea;
    chk("a_ack", bus.a_ack, ea);
    chk("b_ack", bus.b_ack, eb);
    chk("mem_wr", bus.mem_wr, exp_mwr);
    if (exp_xfer) chk("mem_cmd", {bus.mem_wr, bus.mem_slc, bus.mem_row, bus.mem_col, bus.mem_wdata}, exp_cmd);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("a_rvalid", bus.a_rvalid, !rq[0].b);
      chk("b_rvalid", bus.b_rvalid, rq[0].b);
      chk("rdata", rq[0].b ? bus.b_rdata : bus.a_rdata, rq[0].d);
      void'(rq.pop_front());
    end else chk("rvalid_idle", {bus.a_rvalid, bus.b_rvalid}, 0);
    exp_xfer = ea || eb;
    exp_mwr = 0;
    if (exp_xfer) begin
      x = ea ? ca : cb;
      last_a = ea;
      exp_cmd = x;
      exp_mwr = x.wr;
      if (ea) void'(qa.pop_front());
      else void'(qb.pop_front());
      if (x.wr) shadow[x.s][x.r][x.c] = x.d;
      else rq.push_back('{cyc + RD_LAT + 2, eb, shadow[x.s][x.r][x.c]});
    end
    @(posedge clock);
    #1;
  endtask
  task automatic run(int max);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || rq.size() > 0) && n < max) begin
      step();
      n++;
    end
    chk("drain", n < max, 1);
  endtask
  task automatic do_reset();
    bus.a_req = 0;
    bus.b_req = 0;
    reset = 1;
    rq.delete();
    last_a = 0;
    exp_mwr = 0;
    exp_xfer = 0;
    #2;
    chk("rst_mem", {bus.mem_wr, bus.mem_slc, bus.mem_row, bus.mem_col, bus.mem_wdata}, 0);
    chk("rst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 0);
    chk("rst_ack", {bus.a_ack, bus.b_ack}, 0);
`ifdef MDARRAY_ARB_CLEAR_EN
    chk("rst_clr", {clr_busy, clr_done}, 0);
`endif
    @(posedge clock);
    #1;
    reset = 0;
  endtask
  initial begin
    bus.a_req = 0; bus.a_wr = 0; bus.a_slc = 0; bus.a_row = 0; bus.a_col = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_wr = 0; bus.b_slc = 0; bus.b_row = 0; bus.b_col = 0; bus.b_wdata = 0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    for (int s = 0; s < N; s++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) qa.push_back(mk(1, s, r, c, $urandom));
    run(200);
    qa.push_back(mk(1, 1, 2, 3, 'h5A));
    qa.push_back(mk(0, 1, 2, 3, 0));
    run(20);
    for (int i = 0; i < 3; i++) begin
      qa.push_back(rnd());
      qb.push_back(rnd());
    end
    run(30);
    qa.push_back(mk(1, 0, 0, 0, 'h11));
    qa.push_back(mk(1, 0, 0, 1, 'h22));
    qa.push_back(mk(1, 0, 0, 2, 'h33));
    for (int c = 0; c < 3; c++) qa.push_back(mk(0, 0, 0, c, 0));
    run(30);
    qb.push_back(mk(1, 2, 2, 2, 'hC3));
    run(10);
    qa.push_back(mk(0, 1, 2, 3, 0));
    qb.push_back(mk(0, 2, 2, 2, 0));
    run(20);
    qa.push_back(mk(0, 0, 0, 1, 0));
    step();
    step();
    do_reset();
    repeat (8) step();
    qb.push_back(mk(0, 0, 0, 2, 0));
    qa.push_back(mk(0, 0, 0, 0, 0));
    run(20);
`ifdef MDARRAY_ARB_CLEAR_EN
    begin
      int nb, nw, nd;
      bit done;
      clr_start = 1;
      @(posedge clock);
      #1;
      clr_start = 0;
      repeat (5) @(posedge clock);
      #1;
      do_reset();
      nd = 0;
      repeat (80) begin
        @(negedge clock);
        nd += int'(clr_done);
      end
      chk("abort_no_done", nd, 0);
      @(posedge clock);
      #1;
      clr_start = 1;
      @(posedge clock);
      #1;
      clr_start = 0;
      {bus.a_wr, bus.a_slc, bus.a_row, bus.a_col, bus.a_wdata} = mk(0, 3, 3, 3, 0);
      {bus.b_wr, bus.b_slc, bus.b_row, bus.b_col, bus.b_wdata} = mk(0, 1, 1, 1, 0);
      bus.a_req = 1;
      bus.b_req = 1;
      nb = 0;
      nw = 0;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
        @(negedge clock);
        if (clr_busy) begin
          nb++;
          chk("sweep_ack", {bus.a_ack, bus.b_ack}, 0);
        end
        if (bus.mem_wr) begin
          chk("sweep_addr", {bus.mem_slc, bus.mem_row, bus.mem_col}, nw);
          chk("sweep_wdata", bus.mem_wdata, 0);
          nw++;
        end
        done = clr_done;
      end
      bus.a_req = 0;
      bus.b_req = 0;
      chk("sweep_done", done, 1);
      chk("sweep_busy_cycles", nb, N * N * N);
      chk("sweep_writes", nw, N * N * N);
      @(negedge clock);
      chk("done_pulse", {clr_busy, clr_done}, 0);
      @(posedge clock);
      #1;
      exp_mwr = 0;
      exp_xfer = 0;
      for (int s = 0; s < N; s++)
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) shadow[s][r][c] = '0;
      qa.push_back(mk(0, 3, 3, 3, 0));
      qb.push_back(mk(0, 0, 1, 2, 0));
      run(20);
    end
`endif
    for (int i = 0; i < 400; i++) begin
      if (qa.size() == 0 && $urandom_range(9) < 7) qa.push_back(rnd());
      if (qb.size() == 0 && $urandom_range(9) < 5) qb.push_back(rnd());
      step();
    end
    run(50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mdarray_arbiter.md
Name: mdarray_arbiter

Overview:
- Round-robin arbiter sharing one 3-D memory port (slice/row/col addressed, 2-cycle registered read path) between two requesters, A and B.
- Accepts one command per cycle from the granted requester and registers it onto the memory port.
- Tracks outstanding reads and routes each read result back to its owner with a valid strobe.
- Optionally contains a sweep-clear sequencer that zero-fills the whole array.

Parameters:
- IW, 2, index width in bits for slc/row/col.
- N, 4, entries per dimension (N <= 2**IW); legal index range 0..N-1.
- DW, 8, data width.
- RD_LAT, 2, memory read latency: edges from memory address capture to mem_rdata update.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  requester A command valid
- a_wr  in  1  1=write, 0=read
- a_slc, a_row, a_col  in  IW each  A address
- a_wdata  in  DW  A write data
- a_ack  out  1  A command accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  DW  A read data
- b_req, b_wr, b_slc, b_row, b_col, b_wdata, b_ack, b_rvalid, b_rdata  as for A
- mem_slc, mem_row, mem_col  out  IW each  memory address
- mem_wr  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset values:
  - mem_* = 0, a_ack = b_ack = 0, rvalids = 0.
  - Priority pointer favours A.
  - Tag pipeline cleared.
- Acks:
  - a_ack/b_ack are combinational from req, pointer and clear state. No path from mem_rdata.
  - A transfer occurs at the rising edge where req & ack.
  - A requester holds its command stable until the transfer; a deasserted req is never acked.
- Arbitration:
  - Only one requesting: granted.
  - Both requesting: grant the one not granted at the last transfer, then flip the pointer.
  - Pointer changes only on a transfer.
  - Back-to-back transfers every cycle are legal: full throughput from one requester, strict alternation under contention.
- Command register: on a transfer at edge k, mem_slc/row/col/wdata/wr are loaded at edge k.
  - With no transfer, mem_wr = 0 and address/wdata hold their last values.
- Read return:
  - Each accepted read pushes an owner tag into a RD_LAT+1 deep shift register (valid, owner).
  - For a read accepted at edge k, the owner's rvalid is high for exactly the one cycle after edge k+RD_LAT+1.
  - During that cycle rdata = mem_rdata.
  - a_rdata and b_rdata are both wired to mem_rdata and are meaningful only with rvalid.
  - Writes produce no rvalid.
- Read/write ordering: a read accepted one cycle after a write to the same address returns the new data, because the memory commits the write before the read captures.
- Out-of-range index (>= N): passed through unchanged. The requester is responsible for range.
- Reset mid-operation: outstanding read tags are discarded. No rvalid follows reset.

Optional Feature:
- MDARRAY_ARB_CLEAR_EN adds three ports:
  - clr_start in 1
  - clr_busy out 1 (reset 0)
  - clr_done out 1 (reset 0)
- States:
  - IDLE: clr_start = 1 → SWEEP at the next edge.
  - SWEEP: a_ack = b_ack = 0. One write of 0 per cycle, col fastest, then row, then slc, from (0,0,0) to (N-1,N-1,N-1).
  - SWEEP → DONE after the N**3-th write.
  - DONE: clr_done high for one cycle → IDLE.
- clr_busy is high in SWEEP.
- clr_start is ignored while not IDLE.
- Reads accepted before SWEEP still return rvalid normally.
- The pointer is unchanged by the sweep.
- Reset mid-sweep aborts: IDLE, clr_busy = 0, no clr_done.
- Without the macro: the ports are absent and there is no clear logic.

Test Plan:
- A write (1,2,3) ← 0x5A, then A read (1,2,3) → a_ack each cycle; a_rvalid exactly RD_LAT+1 edges after the read accept with a_rdata = 0x5A; b_rvalid stays 0.
- a_req and b_req held high for 6 cycles → acks alternate A,B,A,B,A,B; mem_wr mirrors each granted wr bit.
- A reads 3 consecutive addresses holding 0x11, 0x22, 0x33 → a_rvalid high for 3 consecutive cycles with rdata 0x11, 0x22, 0x33 in order.
- Interleaved reads, A then B, on back-to-back cycles → a_rvalid then b_rvalid on consecutive cycles with the correct data each.
- reset pulsed 1 cycle after a read accept → no rvalid afterwards; all outputs return to 0; next grant favours A.
- With MDARRAY_ARB_CLEAR_EN, N=4: clr_start → 64 write cycles with acks 0, clr_done pulse; a subsequent read of (3,3,3) returns 0x00.
